// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequenced multiply-accumulate controller.
// Accepts len unsigned 8x8 operand pairs and sums their products into a
// 16-bit accumulator (modulo 2^16) with a sticky carry-out flag. The result
// is presented with a valid/ready handshake.
// Datapath: operand handshake -> product register (_p1) -> accumulator (_p2).
module mac_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      acc_out,
  output logic             ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] acc_cnt;
  logic [LEN_W-1:0] issue_nxt;
  logic [LEN_W-1:0] acc_nxt;
  logic             hs_p0;
  logic [15:0]      mul_p0;
  logic [15:0]      prod_p1;
  logic             vld_p1;
  logic [15:0]      acc_p2;
  logic [16:0]      sum_p2;

  // 16-bit Kogge-Stone adder, carry-in tied to zero; returns {cout, sum}.
  function automatic logic [16:0] ks_add16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] gp;
    logic [15:0] gn;
    logic [15:0] pn;
    p  = x ^ y;
    g  = x & y;
    gp = p;
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = gp;
      for (int i = 0; i < 16; i++) begin
        if (i >= d) begin
          gn[i] = g[i] | (gp[i] & g[i-d]);
          pn[i] = gp[i] & gp[i-d];
        end
      end
      g  = gn;
      gp = pn;
    end
    // g[i] now holds the group generate of bits [i:0], i.e. the carry into bit i+1.
    ks_add16 = {g[15], p ^ {g[14:0], 1'b0}};
  endfunction

  // Stage p0: operand handshake and combinational product.
  assign hs_p0     = in_valid && in_ready;
  assign mul_p0    = 16'(a) * 16'(b);
  assign issue_nxt = issue_cnt + 1'b1;

  // Stage p1 -> p2: registered product folded into the accumulator.
  assign sum_p2    = ks_add16(acc_p2, prod_p1);
  assign acc_nxt   = acc_cnt + 1'b1;

  assign acc_out   = acc_p2;

  // Sequencing FSM together with the product and accumulator pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      prod_p1   <= '0;
      vld_p1    <= 1'b0;
      acc_p2    <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          vld_p1 <= 1'b0;
          if (start) begin
            len_r     <= len;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            acc_p2    <= '0;
            ovf       <= 1'b0;
            busy      <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state     <= RUN;
              in_ready  <= 1'b1;
            end
          end
        end

        RUN: begin
          vld_p1 <= hs_p0;
          if (hs_p0) begin
            prod_p1   <= mul_p0;
            issue_cnt <= issue_nxt;
            in_ready  <= (issue_nxt < len_r);
          end
          if (vld_p1) begin
            acc_p2  <= sum_p2[15:0];
            ovf     <= ovf | sum_p2[16];
            acc_cnt <= acc_nxt;
            if (acc_nxt == len_r) begin
              state     <= DONE;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end

        DONE: begin
          vld_p1 <= 1'b0;
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          vld_p1    <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 8, meaning width of the pair-count field.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port start  input  1  begin a new accumulation job, sampled only in IDLE.
REQ-005 The block SHALL have port len  input  LEN_W  number of operand pairs in the job, sampled with start.
REQ-006 The block SHALL have port in_valid  input  1  operand pair on a/b is valid.
REQ-007 The block SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 The block SHALL have ports a and b  input  8 each  unsigned multiplicand and multiplier.
REQ-009 The block SHALL have port out_valid  output  1  acc_out and ovf hold the final job result.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 The block SHALL have port acc_out  output  16  accumulated sum of products, modulo 2^16.
REQ-012 The block SHALL have port ovf  output  1  sticky flag: at least one accumulation produced a carry out of bit 15.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 clears acc, ovf, the issue counter and the accumulate counter, then moves to DONE if len==0, else to RUN.
REQ-016 RUN: in_ready=1 while the issue count is below len, else 0; each in_valid&&in_ready SHALL register a*b (16-bit unsigned) into the product register and increment the issue count.
REQ-017 The edge after a product is registered SHALL update acc <= acc + product, using a 16-bit parallel-prefix adder with cin=0; the block SHALL set ovf on adder carry-out and never clear it within a job.
REQ-018 Pipelining: the block SHALL accept one pair per cycle with no bubbles; pair k accepted at edge T SHALL be reflected in acc at edge T+2.
REQ-019 The block SHALL move from RUN to DONE on the edge that accumulates the len-th product, so out_valid rises 2 cycles after the last input handshake.
REQ-020 DONE: out_valid=1, in_ready=0; acc_out and ovf SHALL hold stable until out_valid&&out_ready, after which the FSM moves to IDLE on that edge.
REQ-021 The block SHALL ignore start in RUN and DONE; len and start changes during a job SHALL have no effect.
REQ-022 With in_valid low, RUN SHALL stall without changing acc except to drain an already registered product.
REQ-023 len==0: out_valid SHALL assert 1 cycle after start, with acc_out=0 and ovf=0.
REQ-024 len at maximum (2^LEN_W-1): counters SHALL NOT wrap, and exactly len pairs SHALL be accepted.
REQ-025 acc_out SHALL expose the acc register in all states; its value outside DONE is not a result.

Reset
REQ-026 The block SHALL act on rst_n low immediately, without waiting for a clock edge, in any state including mid-RUN.
REQ-027 Reset values: state=IDLE, acc_out=0, ovf=0, out_valid=0, in_ready=0, busy=0, counters=0, product register and its valid=0.
REQ-028 After rst_n rises, the block SHALL discard any partial job and require a new start.

Verification
REQ-029 Basic job: start with len=4, pairs 3x4, 5x6, 7x8, 9x10 back-to-back -> out_valid 2 cycles after the 4th handshake, acc_out=0x00BC, ovf=0.
REQ-030 Overflow: len=2, pairs 255x255 twice -> acc_out=0xFC02, ovf=1.
REQ-031 Zero length: start with len=0 -> out_valid 1 cycle later, acc_out=0x0000, ovf=0, no in_ready pulse.
REQ-032 Backpressure both sides: len=3, in_valid toggled randomly, out_ready held low 5 cycles -> correct sum, result stable throughout the stall, return to IDLE on the out_ready handshake.
REQ-033 Reset mid-RUN: drop rst_n after 2 of 4 pairs -> outputs reach their reset values asynchronously; a new job (len=1, 2x3) then yields 0x0006.
REQ-034 Ignored start: pulse start with different len during RUN and DONE -> the current job's count and result are unaffected.
